// File: rtl/imbalance_alarm.sv
// Hysteresis alarm on a per-frame IEEE754 asymmetry coefficient, with consecutive-run
// qualification and a peak hold for the current or most recent imbalance event.
module imbalance_alarm #(
  parameter logic [31:0] TRIP_TH   = 32'h3E4CCCCD,
  parameter logic [31:0] CLEAR_TH  = 32'h3DCCCCCD,
  parameter int unsigned TRIP_CNT  = 3,
  parameter int unsigned CLEAR_CNT = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             coffValid,
  input  logic [31:0]      coff,
  output logic             dataOut,
  output logic             alarm,
  output logic             tripPulse,
  output logic             clearPulse,
  output logic             invalid,
  output logic [31:0]      peak,
  output logic [CNT_W-1:0] runCnt
);

  typedef enum logic [1:0] {NORMAL, PEND_TRIP, ALARM, PEND_CLEAR} state_e;

  localparam logic [CNT_W-1:0] TRIP_N  = CNT_W'(TRIP_CNT);
  localparam logic [CNT_W-1:0] CLEAR_N = CNT_W'(CLEAR_CNT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic             alarm_q, alarm_d;
  logic             trip_q, trip_d;
  logic             clear_q, clear_d;
  logic             inv_q, inv_d;
  logic [31:0]      peak_q, peak_d;
  logic [CNT_W-1:0] run_q, run_d;

  logic             rise, hi, lo;
  logic [30:0]      mag;
  logic [31:0]      peak_max;
  logic [CNT_W-1:0] run_inc;

  always_comb begin
    rise     = coffValid & ~valid_q;
    // Negative coefficients compare as zero, so the sign bit never reaches peak.
    mag      = coff[31] ? '0 : coff[30:0];
    hi       = (mag >= TRIP_TH[30:0]);
    lo       = (mag <= CLEAR_TH[30:0]);
    run_inc  = (run_q == '1) ? run_q : run_q + ONE;
    peak_max = ({1'b0, mag} > peak_q) ? {1'b0, mag} : peak_q;

    state_d = state_q;
    valid_d = coffValid;
    run_d   = run_q;
    peak_d  = peak_q;
    data_d  = 1'b0;
    trip_d  = 1'b0;
    clear_d = 1'b0;
    inv_d   = 1'b0;

    if (rise) begin
      data_d = 1'b1;
      if (coff[30:23] == 8'hFF) begin
        inv_d = 1'b1;
      end else begin
        case (state_q)
          NORMAL: begin
            if (hi) begin
              peak_d = {1'b0, mag};
              run_d  = ONE;
              if (TRIP_N == ONE) begin
                state_d = ALARM;
                trip_d  = 1'b1;
              end else begin
                state_d = PEND_TRIP;
              end
            end else begin
              run_d = '0;
            end
          end
          PEND_TRIP: begin
            if (hi) begin
              run_d  = run_inc;
              peak_d = peak_max;
              if (run_inc == TRIP_N) begin
                state_d = ALARM;
                trip_d  = 1'b1;
              end
            end else begin
              state_d = NORMAL;
              run_d   = '0;
            end
          end
          ALARM: begin
            peak_d = peak_max;
            if (lo) begin
              run_d = ONE;
              if (CLEAR_N == ONE) begin
                state_d = NORMAL;
                clear_d = 1'b1;
              end else begin
                state_d = PEND_CLEAR;
              end
            end else begin
              run_d = '0;
            end
          end
          default: begin
            peak_d = peak_max;
            if (lo) begin
              run_d = run_inc;
              if (run_inc == CLEAR_N) begin
                state_d = NORMAL;
                clear_d = 1'b1;
                run_d   = '0;
              end
            end else begin
              state_d = ALARM;
              run_d   = '0;
            end
          end
        endcase
      end
    end

    alarm_d = (state_d == ALARM) || (state_d == PEND_CLEAR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= NORMAL;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      alarm_q <= 1'b0;
      trip_q  <= 1'b0;
      clear_q <= 1'b0;
      inv_q   <= 1'b0;
      peak_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      alarm_q <= alarm_d;
      trip_q  <= trip_d;
      clear_q <= clear_d;
      inv_q   <= inv_d;
      peak_q  <= peak_d;
      run_q   <= run_d;
    end
  end

  assign dataOut    = data_q;
  assign alarm      = alarm_q;
  assign tripPulse  = trip_q;
  assign clearPulse = clear_q;
  assign invalid    = inv_q;
  assign peak       = peak_q;
  assign runCnt     = run_q;

endmodule

// File: tb/tb_imbalance_alarm.sv
// Directed bench for imbalance_alarm: hand-computed flag/run/peak expectations per frame.
module tb_imbalance_alarm;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        coffValid = 1'b0;
  logic [31:0] coff = '0;
  logic        dataOut, alarm, tripPulse, clearPulse, invalid;
  logic [31:0] peak;
  logic [7:0]  runCnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Captured outputs of the most recent frame; flags = {dataOut,trip,clear,invalid,alarm}.
  logic [4:0]  o_flags;
  logic [7:0]  o_run;
  logic [31:0] o_peak;

  imbalance_alarm #(
    .TRIP_TH  (32'h3E4CCCCD),
    .CLEAR_TH (32'h3DCCCCCD),
    .TRIP_CNT (3),
    .CLEAR_CNT(3),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .coffValid (coffValid),
    .coff      (coff),
    .dataOut   (dataOut),
    .alarm     (alarm),
    .tripPulse (tripPulse),
    .clearPulse(clearPulse),
    .invalid   (invalid),
    .peak      (peak),
    .runCnt    (runCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic frame(input logic [31:0] v);
    @(negedge clk);
    coffValid = 1'b1;
    coff      = v;
    @(negedge clk);
    o_flags   = {dataOut, tripPulse, clearPulse, invalid, alarm};
    o_run     = runCnt;
    o_peak    = peak;
    coffValid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({dataOut, tripPulse, clearPulse, invalid, alarm, runCnt, peak} !== 45'd0) begin
      errors++;
      $display("FAIL reset_values: got flags=%b run=%0d peak=%h, expected all zero",
               {dataOut, tripPulse, clearPulse, invalid, alarm}, runCnt, peak);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_trip();
    logic [31:0] v [3];
    logic [4:0]  ef [3];
    logic [7:0]  er [3];
    v  = '{32'h3E800000, 32'h3E800000, 32'h3E800000};
    ef = '{5'b10000, 5'b10000, 5'b11001};
    er = '{8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 3; i++) begin
      frame(v[i]);
      checks++;
      if (o_flags !== ef[i] || o_run !== er[i]) begin
        errors++;
        $display("FAIL trip[%0d]: got flags=%b run=%0d, expected flags=%b run=%0d",
                 i, o_flags, o_run, ef[i], er[i]);
      end
    end
    checks++;
    if (o_peak !== 32'h3E800000) begin
      errors++;
      $display("FAIL trip_peak: got %h, expected 3e800000", o_peak);
    end
    @(negedge clk);
    checks++;
    if ({dataOut, tripPulse} !== 2'b00) begin
      errors++;
      $display("FAIL trip_pulse_width: got dataOut,trip=%b, expected 00", {dataOut, tripPulse});
    end
  endtask

  task automatic test_clear_hold();
    logic [31:0] v [3];
    logic [7:0]  er [3];
    logic [31:0] ep [3];
    v  = '{32'h3D4CCCCD, 32'h3E99999A, 32'h3D4CCCCD};
    er = '{8'd1, 8'd0, 8'd1};
    ep = '{32'h3E800000, 32'h3E99999A, 32'h3E99999A};
    for (int i = 0; i < 3; i++) begin
      frame(v[i]);
      checks++;
      if (o_flags !== 5'b10001 || o_run !== er[i] || o_peak !== ep[i]) begin
        errors++;
        $display("FAIL clear_hold[%0d]: got flags=%b run=%0d peak=%h, expected flags=10001 run=%0d peak=%h",
                 i, o_flags, o_run, o_peak, er[i], ep[i]);
      end
    end
  endtask

  task automatic test_invalid_negative();
    logic [31:0] v [4];
    logic [4:0]  ef [4];
    logic [7:0]  er [4];
    v  = '{32'h7FC00000, 32'hBE800000, 32'h3D4CCCCD, 32'h7F800000};
    ef = '{5'b10011, 5'b10001, 5'b10100, 5'b10010};
    er = '{8'd1, 8'd2, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      frame(v[i]);
      checks++;
      if (o_flags !== ef[i] || o_run !== er[i] || o_peak !== 32'h3E99999A) begin
        errors++;
        $display("FAIL invalid_negative[%0d]: got flags=%b run=%0d peak=%h, expected flags=%b run=%0d peak=3e99999a",
                 i, o_flags, o_run, o_peak, ef[i], er[i]);
      end
    end
  endtask

  task automatic test_broken_trip();
    logic [31:0] v [4];
    logic [7:0]  er [4];
    v  = '{32'h3E800000, 32'h3E800000, 32'h3E19999A, 32'h3E800000};
    er = '{8'd1, 8'd2, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      frame(v[i]);
      checks++;
      if (o_flags !== 5'b10000 || o_run !== er[i] || o_peak !== 32'h3E800000) begin
        errors++;
        $display("FAIL broken_trip[%0d]: got flags=%b run=%0d peak=%h, expected flags=10000 run=%0d peak=3e800000",
                 i, o_flags, o_run, o_peak, er[i]);
      end
    end
  endtask

  task automatic test_thresholds();
    logic [31:0] v [7];
    logic [4:0]  ef [7];
    logic [7:0]  er [7];
    logic [31:0] ep [7];
    v  = '{32'h3E4CCCCC, 32'h3E4CCCCD, 32'h3E4CCCCD, 32'h3E4CCCCD,
           32'h3DCCCCCE, 32'h3DCCCCCD, 32'h3E800000};
    ef = '{5'b10000, 5'b10000, 5'b10000, 5'b11001, 5'b10001, 5'b10001, 5'b10001};
    er = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd0};
    ep = '{32'h3E800000, 32'h3E4CCCCD, 32'h3E4CCCCD, 32'h3E4CCCCD,
           32'h3E4CCCCD, 32'h3E4CCCCD, 32'h3E800000};
    for (int i = 0; i < 7; i++) begin
      frame(v[i]);
      checks++;
      if (o_flags !== ef[i] || o_run !== er[i] || o_peak !== ep[i]) begin
        errors++;
        $display("FAIL thresholds[%0d]: got flags=%b run=%0d peak=%h, expected flags=%b run=%0d peak=%h",
                 i, o_flags, o_run, o_peak, ef[i], er[i], ep[i]);
      end
    end
  endtask

  task automatic test_clear();
    logic [4:0] ef [3];
    logic [7:0] er [3];
    ef = '{5'b10001, 5'b10001, 5'b10100};
    er = '{8'd1, 8'd2, 8'd0};
    for (int i = 0; i < 3; i++) begin
      frame(32'h3D4CCCCD);
      checks++;
      if (o_flags !== ef[i] || o_run !== er[i] || o_peak !== 32'h3E800000) begin
        errors++;
        $display("FAIL clear[%0d]: got flags=%b run=%0d peak=%h, expected flags=%b run=%0d peak=3e800000",
                 i, o_flags, o_run, o_peak, ef[i], er[i]);
      end
    end
  endtask

  task automatic test_held_valid();
    int unsigned pulses = 0;
    @(negedge clk);
    coffValid = 1'b1;
    coff      = 32'h3E800000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dataOut === 1'b1) pulses++;
    end
    coffValid = 1'b0;
    @(negedge clk);
    if (dataOut === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || runCnt !== 8'd1) begin
      errors++;
      $display("FAIL held_valid: got pulses=%0d run=%0d, expected pulses=1 run=1", pulses, runCnt);
    end
  endtask

  task automatic test_reset_mid_event();
    frame(32'h3E800000);
    frame(32'h3E800000);
    checks++;
    if (o_flags !== 5'b11001 || o_run !== 8'd3) begin
      errors++;
      $display("FAIL mid_reset_setup: got flags=%b run=%0d, expected flags=11001 run=3", o_flags, o_run);
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({alarm, peak, runCnt} !== 41'd0) begin
      errors++;
      $display("FAIL async_reset: got alarm=%b peak=%h run=%0d, expected 0 0 0", alarm, peak, runCnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    frame(32'h3E800000);
    checks++;
    if (o_flags !== 5'b10000 || o_run !== 8'd1 || o_peak !== 32'h3E800000) begin
      errors++;
      $display("FAIL after_reset: got flags=%b run=%0d peak=%h, expected flags=10000 run=1 peak=3e800000",
               o_flags, o_run, o_peak);
    end
  endtask

  initial begin
    test_reset();
    test_trip();
    test_clear_hold();
    test_invalid_negative();
    test_broken_trip();
    test_thresholds();
    test_clear();
    test_held_valid();
    test_reset_mid_event();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
